row_collect_m: RTL and testbench

Sink-side counterpart of the row arithmetic units. Accepts a stream of 40-bit result rows (5 signed int8 elements each) plus per-row overflow flags over a valid/ready handshake. Assembles them into a full 5x5 result matrix, masked to the active matrix size, with a sticky overflow flag. Presents the matrix with a one-cycle done pulse to the coprocessor control/write-back stage.

---
 rtl/row_collect_m.sv | 102 ++++++++++
 tb/tb_row_collect_m.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/row_collect_m.sv
// Collects a stream of result rows into a 5x5 matrix, masked to the active size.
// Raises a sticky overflow flag and a one-cycle done pulse for write-back.
module row_collect_m #(
  parameter int ROWS = 5,
  parameter int EW   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [2:0]                size,
  input  logic [ROWS*EW-1:0]        row_in,
  input  logic                      row_ovf,
  input  logic                      row_valid,
  output logic                      row_ready,
  output logic [ROWS*ROWS*EW-1:0]   m_res,
  output logic                      ovf_out,
  output logic                      done,
  output logic                      busy,
  output logic                      err
);

  // state   | meaning
  // IDLE    | waiting for start; m_res/ovf_out hold the last matrix
  // COLLECT | accepting rows, one per handshake, into slot idx
  // DONE    | matrix complete; done pulses for this single cycle

  localparam int RW = ROWS * EW;
  localparam logic [2:0] MAX_SIZE = 3'(ROWS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    idx;
  logic [2:0]    size_q;
  logic [RW-1:0] row_masked;
  logic          size_ok;

  assign size_ok   = (size >= 3'd2) && (size <= MAX_SIZE);
  assign row_ready = (state == S_COLLECT);

  // Element 0 sits in the most significant byte; columns at or beyond size are zeroed.
  always_comb begin
    row_masked = '0;
    for (int c = 0; c < ROWS; c++) begin
      if (c < int'(size_q))
        row_masked[(ROWS-1-c)*EW +: EW] = row_in[(ROWS-1-c)*EW +: EW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      idx     <= '0;
      size_q  <= '0;
      m_res   <= '0;
      ovf_out <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (size_ok) begin
              size_q  <= size;
              m_res   <= '0;
              ovf_out <= 1'b0;
              idx     <= '0;
              busy    <= 1'b1;
              state   <= S_COLLECT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (row_valid) begin
            m_res[(ROWS-1-int'(idx))*RW +: RW] <= row_masked;
            ovf_out <= ovf_out | row_ovf;
            idx     <= idx + 3'd1;
            if (idx == size_q - 3'd1) begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_collect_m.sv
// Randomised and directed checks of row_collect_m against a matrix-level model:
// expected matrices are built from element arrays and the active size.
module tb_row_collect_m;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   size;
  logic [39:0]  row_in;
  logic         row_ovf;
  logic         row_valid;
  logic         row_ready;
  logic [199:0] m_res;
  logic         ovf_out;
  logic         done;
  logic         busy;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]   el [5][5];
  logic         ovf_a [5];
  logic [199:0] held_m;
  logic         held_ovf;

  row_collect_m dut (
    .clk(clk), .rst(rst), .start(start), .size(size),
    .row_in(row_in), .row_ovf(row_ovf), .row_valid(row_valid),
    .row_ready(row_ready), .m_res(m_res), .ovf_out(ovf_out),
    .done(done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [199:0] obs, logic [199:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] row_of(int r);
    logic [39:0] v;
    for (int c = 0; c < 5; c++) v[39-8*c -: 8] = el[r][c];
    return v;
  endfunction

  // Expected matrix: element (r,c) kept only when both r and c are inside the active size.
  function automatic logic [199:0] exp_matrix(int sz);
    logic [199:0] m;
    m = '0;
    for (int r = 0; r < sz; r++)
      for (int c = 0; c < sz; c++)
        m[199-40*r-8*c -: 8] = el[r][c];
    return m;
  endfunction

  // gap: 0 continuous valid, 1 alternate 1/0, 2 random. poke: pulse start while busy.
  task automatic run_matrix(int sz, int gap, bit poke, string tag);
    int  acc;
    int  cyc;
    bit  v;
    logic exp_ovf;
    acc = 0; cyc = 0; exp_ovf = 1'b0;
    start = 1'b1; size = 3'(sz);
    tick();
    start = 1'b0;
    chk({tag, "_busy0"}, 200'(busy), 200'(1));
    chk({tag, "_rdy0"}, 200'(row_ready), 200'(1));
    chk({tag, "_clr"}, m_res, '0);
    chk({tag, "_ovf0"}, 200'(ovf_out), 200'(0));
    while (acc < sz) begin
      case (gap)
        0: v = 1'b1;
        1: v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      row_valid = v;
      row_in  = v ? row_of(acc) : 40'($urandom) ^ {8'($urandom), 32'h0};
      row_ovf = v ? ovf_a[acc] : 1'b1;
      start   = poke && ($urandom_range(0, 2) == 0);
      size    = 3'($urandom_range(2, 5));
      tick();
      if (v) begin
        exp_ovf = exp_ovf | ovf_a[acc];
        acc++;
      end
      cyc++;
      if (acc < sz) begin
        chk({tag, "_done_early"}, 200'(done), 200'(0));
        chk({tag, "_rdy"}, 200'(row_ready), 200'(1));
        chk({tag, "_ovf_run"}, 200'(ovf_out), 200'(exp_ovf));
      end
      if (cyc > 200) begin
        chk({tag, "_timeout"}, 200'(acc), 200'(sz));
        break;
      end
    end
    row_valid = 1'b0; start = 1'b0;
    chk({tag, "_done"}, 200'(done), 200'(1));
    chk({tag, "_rdy_done"}, 200'(row_ready), 200'(0));
    chk({tag, "_busy_done"}, 200'(busy), 200'(1));
    chk({tag, "_mres"}, m_res, exp_matrix(sz));
    chk({tag, "_ovf"}, 200'(ovf_out), 200'(exp_ovf));
    tick();
    chk({tag, "_done_once"}, 200'(done), 200'(0));
    chk({tag, "_idle"}, 200'(busy), 200'(0));
    tick();
    chk({tag, "_hold"}, m_res, exp_matrix(sz));
    chk({tag, "_hold_ovf"}, 200'(ovf_out), 200'(exp_ovf));
    held_m = exp_matrix(sz);
    held_ovf = exp_ovf;
  endtask

  task automatic bad_start(int sz);
    start = 1'b1; size = 3'(sz);
    tick();
    start = 1'b0;
    chk("err_pulse", 200'(err), 200'(1));
    chk("err_idle", 200'(busy), 200'(0));
    chk("err_rdy", 200'(row_ready), 200'(0));
    tick();
    chk("err_once", 200'(err), 200'(0));
    chk("err_hold", m_res, held_m);
    chk("err_hold_ovf", 200'(ovf_out), 200'(held_ovf));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; size = '0; row_in = '0; row_ovf = 1'b0; row_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_mres", m_res, '0);
    chk("rst_busy", 200'(busy), 200'(0));
    chk("rst_rdy", 200'(row_ready), 200'(0));
    chk("rst_done", 200'(done), 200'(0));
    chk("rst_err", 200'(err), 200'(0));
    tick();

    // Reset mid-collection, together with a start request.
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) el[r][c] = 8'($urandom);
    start = 1'b1; size = 3'd5;
    tick();
    start = 1'b0; row_valid = 1'b1; row_ovf = 1'b1;
    row_in = row_of(0); tick();
    row_in = row_of(1); tick();
    row_valid = 1'b0; rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("midrst_mres", m_res, '0);
    chk("midrst_ovf", 200'(ovf_out), 200'(0));
    chk("midrst_busy", 200'(busy), 200'(0));
    chk("midrst_rdy", 200'(row_ready), 200'(0));
    tick();
    held_m = '0; held_ovf = 1'b0;

    // Full 5x5, incrementing bytes, no overflow.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) el[r][c] = 8'(r*5 + c + 1);
      ovf_a[r] = 1'b0;
    end
    run_matrix(5, 0, 1'b0, "full5");

    // Size 3 with all-ones rows: columns and rows past 3 must read zero.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) el[r][c] = 8'hFF;
      ovf_a[r] = 1'b0;
    end
    run_matrix(3, 0, 1'b0, "mask3");
    chk("mask3_row0", 200'(m_res[199:160]), 200'(40'hFFFFFF0000));

    // Sticky overflow with gaps; non-accepted cycles carry row_ovf=1.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) el[r][c] = 8'($urandom);
      ovf_a[r] = (r == 1);
    end
    run_matrix(4, 1, 1'b0, "sticky4");

    bad_start(1);
    bad_start(6);
    bad_start(0);
    bad_start(7);

    // Start pulses during collection must be ignored.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) el[r][c] = 8'($urandom);
      ovf_a[r] = 1'b0;
    end
    run_matrix(5, 2, 1'b1, "poke5");

    for (int t = 0; t < 30; t++) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) el[r][c] = 8'($urandom);
        ovf_a[r] = ($urandom_range(0, 5) == 0);
      end
      run_matrix(int'($urandom_range(2, 5)), int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 4) == 0) bad_start(($urandom_range(0, 1) == 0) ? 1 : 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
